// File: rtl/mp_mul_pkg.sv
// Shared definitions for the multi-precision multiplier family: limb geometry
// helpers, default radix/limb widths and the sequencer state type.
package mp_mul_pkg;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    localparam int unsigned RADIX_DEF  = 78;
    localparam int unsigned A_LIMB_DEF = 26;
    localparam int unsigned B_LIMB_DEF = 17;
    localparam int unsigned NA_DEF     = ceil_div(RADIX_DEF, A_LIMB_DEF);
    localparam int unsigned NB_DEF     = ceil_div(RADIX_DEF, B_LIMB_DEF);
    localparam int unsigned PROD_W_DEF = 2 * RADIX_DEF;
    localparam int unsigned ROW_W_DEF  = RADIX_DEF + B_LIMB_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mp_mul_seq_row.sv
// Combinational row multiplier: full operand a times one b limb, built from
// NA narrow multipliers so DSP mapping happens in exactly one place.
module mp_row_mul
    import mp_mul_pkg::*;
#(
    parameter int unsigned RADIX  = RADIX_DEF,
    parameter int unsigned A_LIMB = A_LIMB_DEF,
    parameter int unsigned B_LIMB = B_LIMB_DEF
) (
    input  logic [RADIX-1:0]        a,
    input  logic [B_LIMB-1:0]       b_limb,
    output logic [RADIX+B_LIMB-1:0] row
);

    localparam int unsigned NA = ceil_div(RADIX, A_LIMB);
    localparam int unsigned AW = NA * A_LIMB;
    localparam int unsigned PW = A_LIMB + B_LIMB;
    localparam int unsigned SW = AW + B_LIMB;

    logic [AW-1:0] a_pad;
    logic [PW-1:0] limb_prod [NA];
    logic [SW-1:0] sum;

    always_comb begin
        a_pad            = '0;
        a_pad[RADIX-1:0] = a;
    end

    for (genvar i = 0; i < NA; i++) begin : g_mul
        assign limb_prod[i] = PW'(a_pad[i*A_LIMB +: A_LIMB]) * PW'(b_limb);
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NA; i++) begin
            sum = sum + (SW'(limb_prod[i]) << (i * A_LIMB));
        end
    end

    // a < 2^RADIX, so the true row always fits in RADIX+B_LIMB bits
    assign row = sum[RADIX+B_LIMB-1:0];

endmodule

// File: rtl/mp_mul_seq.sv
// Row-serial multi-precision multiplier: one b limb per cycle through the row
// multiplier into pp, then shifted and accumulated into a 2*RADIX product.
module mp_mul_seq
    import mp_mul_pkg::*;
#(
    parameter int unsigned RADIX  = RADIX_DEF,
    parameter int unsigned A_LIMB = A_LIMB_DEF,
    parameter int unsigned B_LIMB = B_LIMB_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADIX-1:0]   a,
    input  logic [RADIX-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*RADIX-1:0] product,
    output logic               busy
);

    localparam int unsigned NB    = ceil_div(RADIX, B_LIMB);
    localparam int unsigned BW    = NB * B_LIMB;
    localparam int unsigned ROW_W = RADIX + B_LIMB;
    localparam int unsigned ACC_W = 2 * RADIX;
    localparam int unsigned JW    = $clog2(NB + 1);

    state_t              state_q, state_d;
    logic [JW-1:0]       j_q, j_d;
    logic [RADIX-1:0]    a_q, a_d;
    logic [BW-1:0]       b_q, b_d;
    logic [ROW_W-1:0]    pp_q, pp_d;
    logic [ACC_W-1:0]    acc_q, acc_d;

    logic [BW-1:0]       b_pad;
    logic [B_LIMB-1:0]   b_limb;
    logic [ROW_W-1:0]    row;
    logic [ACC_W-1:0]    pp_sh;

    always_comb begin
        b_pad            = '0;
        b_pad[RADIX-1:0] = b;
    end

    always_comb begin
        b_limb = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            if (j_q == JW'(j)) b_limb = b_q[j*B_LIMB +: B_LIMB];
        end
    end

    mp_row_mul #(
        .RADIX (RADIX),
        .A_LIMB(A_LIMB),
        .B_LIMB(B_LIMB)
    ) u_row (
        .a     (a_q),
        .b_limb(b_limb),
        .row   (row)
    );

    // pp holds row j-1 while the counter points at j; at j==0 pp is zero
    always_comb begin
        pp_sh = '0;
        for (int unsigned j = 1; j <= NB; j++) begin
            if (j_q == JW'(j)) pp_sh = ACC_W'(pp_q) << ((j - 1) * B_LIMB);
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        pp_d    = pp_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_pad;
                    pp_d    = '0;
                    acc_d   = '0;
                    j_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = acc_q + pp_sh;
                if (j_q < JW'(NB)) begin
                    pp_d = row;
                    j_d  = j_q + JW'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pp_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pp_q    <= pp_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = acc_q;

endmodule

// File: tb/tb_mp_mul_seq.sv
// Scoreboard bench for mp_mul_seq: the driver pushes a*b on each accepted
// operand pair, an independent monitor pops and checks each delivered product.
module tb_mp_mul_seq;

    localparam int RADIX = 78;
    localparam int PW    = 2 * RADIX;
    localparam int NB    = 5;
    localparam int LAT   = NB + 2;
    localparam int II    = NB + 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [RADIX-1:0] a;
    logic [RADIX-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    product;
    logic             busy;

    mp_mul_seq #(
        .RADIX (78),
        .A_LIMB(26),
        .B_LIMB(17)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    typedef struct {
        logic [PW-1:0] prod;
        longint        t;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_hs = 0;
    bit     hs_valid = 0;
    bit     rand_rdy = 0;
    bit     force_rdy = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [RADIX-1:0] x, input logic [RADIX-1:0] y);
        logic [PW-1:0] wx, wy;
        wx = PW'(x);
        wy = PW'(y);
        return wx * wy;
    endfunction

    function automatic logic [RADIX-1:0] rnd78();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[RADIX-1:0];
    endfunction

    // out_ready: scripted in directed phases, random in the soak phase
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : force_rdy;
        end
    end

    task automatic issue(input logic [RADIX-1:0] av, input logic [RADIX-1:0] bv);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (hs_valid) check("init_interval", PW'(cyc - last_hs >= II), PW'(1));
                last_hs  = cyc;
                hs_valid = 1;
                sb.push_back('{prod: ref_mul(av, bv), t: cyc});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", PW'(0), PW'(1));
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check("drain_timeout", PW'(sb.size()), PW'(0));
    endtask

    // Monitor: latency, hold-while-stalled, product value, in_ready after transfer
    logic          prev_ov = 0;
    logic          prev_or = 0;
    logic          prev_xfer = 0;
    logic [PW-1:0] prev_prod = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov   = 0;
                prev_or   = 0;
                prev_xfer = 0;
            end else begin
                if (prev_xfer) check("in_ready_after_xfer", PW'(in_ready), PW'(1));
                if (prev_ov && !prev_or) begin
                    check("hold_valid", PW'(out_valid), PW'(1));
                    check("hold_product", product, prev_prod);
                end
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) check("unexpected_out_valid", PW'(1), PW'(0));
                    else check("latency", PW'(cyc - sb[0].t), PW'(LAT));
                end
                prev_xfer = 0;
                if (out_valid && out_ready) begin
                    if (sb.size() != 0) begin
                        check("product", product, sb[0].prod);
                        void'(sb.pop_front());
                    end
                    prev_xfer = 1;
                end
                prev_ov   = out_valid;
                prev_or   = out_ready;
                prev_prod = product;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RADIX-1:0] ones;
        logic [RADIX-1:0] top;
        bit               seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", PW'(in_ready), PW'(0));
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_product", product, PW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", PW'(in_ready), PW'(1));
        @(posedge clk);
        #1;

        force_rdy = 1;
        issue(78'd1, 78'd1);
        wait_idle();

        ones = '1;
        issue(ones, ones);
        wait_idle();

        top = '0;
        top[77] = 1'b1;
        issue(78'd3, top);
        wait_idle();
        issue(78'd0, rnd78());
        wait_idle();

        // Consumer stall: product must be held and new operands refused
        force_rdy = 0;
        issue(rnd78(), rnd78());
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            @(posedge clk);
            #1;
        end
        if (!seen) check("stall_out_valid_timeout", PW'(0), PW'(1));
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = rnd78();
            b        = rnd78();
            @(negedge clk);
            check("stall_in_ready", PW'(in_ready), PW'(0));
            check("stall_busy", PW'(busy), PW'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stall_no_accept", PW'(sb.size()), PW'(1));
        force_rdy = 1;
        wait_idle();

        // Abort mid-operation with reset
        issue(rnd78(), rnd78());
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        hs_valid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", PW'(out_valid), PW'(0));
        check("abort_busy", PW'(busy), PW'(0));
        check("abort_acc", product, PW'(0));
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        issue(78'd5, 78'd7);
        wait_idle();

        // Random soak with back-to-back issue and consumer stalls
        hs_valid = 0;
        rand_rdy = 1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 7))
                0:       issue('0, rnd78());
                1:       issue('1, rnd78());
                default: issue(rnd78(), rnd78());
            endcase
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
